// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump client: regfile geometry
// and the dump FSM state encoding, also used by the regfile and core stall logic.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Streaming output bundle of the dump client: one beat per register,
// carrying the register value, its index and a last-register flag.
interface regfile_dump_if;
    import regfile_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Register-file dump client. On start it reads every register through one
// regfile read port and streams the values out one beat at a time, holding
// the core off the regfile write port while the walk is in progress.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter bit SKIP_X0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    regfile_dump_if.master    dump,
    output logic              busy,
    output logic              stall_req,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_X0 ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx;

    // The read address is the walk counter itself; it sits at 0 whenever idle.
    assign rf_addr = idx;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort beats start in IDLE and cancels any active state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (dump.out_ready) begin
                    state_nxt = dump.out_last ? DONE : FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Walk counter, beat capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx            <= '0;
            dump.out_valid <= 1'b0;
            dump.out_data  <= '0;
            dump.out_idx   <= '0;
            dump.out_last  <= 1'b0;
            busy           <= 1'b0;
            stall_req      <= 1'b0;
            done           <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE);
            stall_req <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);

            case (state)
                IDLE: begin
                    if (state_nxt == FETCH) begin
                        idx <= FIRST_IDX;
                    end
                end
                FETCH: begin
                    if (state_nxt == SEND) begin
                        dump.out_data  <= rf_data;
                        dump.out_idx   <= idx;
                        dump.out_last  <= (idx == LAST_IDX);
                        dump.out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (dump.out_ready) begin
                        dump.out_valid <= 1'b0;
                    end
                    if (state_nxt == FETCH) begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase

            if (state_nxt == IDLE) begin
                idx            <= '0;
                dump.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: two instances (x0 included / x0 skipped) share
// one preloaded register array; expected beats are queued as each dump is
// launched and popped by per-instance monitors on every accepted beat.
module tb_regfile_dump;
    import regfile_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start0 = 1'b0, abort0 = 1'b0;
    logic              start1 = 1'b0, abort1 = 1'b0;
    logic [ADDR_W-1:0] rf_addr0, rf_addr1;
    logic [DATA_W-1:0] rf_data0, rf_data1;
    logic              busy0, stall0, done0;
    logic              busy1, stall1, done1;
    logic [DATA_W-1:0] regs [NUM_REGS];

    int    errors = 0;
    int    checks = 0;
    int    beats0 = 0, beats1 = 0;
    int    dones0 = 0, dones1 = 0;
    beat_t expq0[$];
    beat_t expq1[$];

    regfile_dump_if if0();
    regfile_dump_if if1();

    regfile_dump #(.SKIP_X0(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .rf_addr(rf_addr0), .rf_data(rf_data0), .dump(if0.master),
        .busy(busy0), .stall_req(stall0), .done(done0)
    );

    regfile_dump #(.SKIP_X0(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .rf_addr(rf_addr1), .rf_data(rf_data1), .dump(if1.master),
        .busy(busy1), .stall_req(stall1), .done(done1)
    );

    // Combinational regfile read ports; x0 always reads as zero.
    assign rf_data0 = (rf_addr0 == '0) ? '0 : regs[rf_addr0];
    assign rf_data1 = (rf_addr1 == '0) ? '0 : regs[rf_addr1];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor for the x0-included instance: compare each accepted beat.
    always @(negedge clk) begin
        if (!reset && if0.out_valid && if0.out_ready) begin
            beats0++;
            if (expq0.size() == 0) begin
                checkOutput("dut0 unexpected beat", {59'd0, if0.out_idx}, 64'hFFFF);
            end else begin
                beat_t e;
                e = expq0.pop_front();
                checkOutput("dut0 beat idx", {59'd0, if0.out_idx}, {59'd0, e.idx});
                checkOutput("dut0 beat data", {32'd0, if0.out_data}, {32'd0, e.data});
                checkOutput("dut0 beat last", {63'd0, if0.out_last}, {63'd0, e.last});
            end
        end
        if (!reset && done0) dones0++;
    end

    // Monitor for the x0-skipping instance.
    always @(negedge clk) begin
        if (!reset && if1.out_valid && if1.out_ready) begin
            beats1++;
            if (expq1.size() == 0) begin
                checkOutput("dut1 unexpected beat", {59'd0, if1.out_idx}, 64'hFFFF);
            end else begin
                beat_t e;
                e = expq1.pop_front();
                checkOutput("dut1 beat idx", {59'd0, if1.out_idx}, {59'd0, e.idx});
                checkOutput("dut1 beat data", {32'd0, if1.out_data}, {32'd0, e.data});
                checkOutput("dut1 beat last", {63'd0, if1.out_last}, {63'd0, e.last});
            end
        end
        if (!reset && done1) dones1++;
    end

    task automatic pushDump(input int which, input int first);
        for (int i = first; i < NUM_REGS; i++) begin
            beat_t b;
            b.idx  = ADDR_W'(i);
            b.data = (i == 0) ? 32'd0 : regs[i];
            b.last = (i == NUM_REGS - 1);
            if (which == 0) expq0.push_back(b);
            else            expq1.push_back(b);
        end
    endtask

    task automatic applyStimulus(input int which, input bit s, input bit a);
        @(posedge clk); #1;
        if (which == 0) begin start0 = s; abort0 = a; end
        else            begin start1 = s; abort1 = a; end
        @(posedge clk); #1;
        if (which == 0) begin start0 = 1'b0; abort0 = 1'b0; end
        else            begin start1 = 1'b0; abort1 = 1'b0; end
    endtask

    task automatic runUntilIdle(input int which, input string name, output int busyCycles, output int doneAt);
        int  stallErr;
        bit  finished;
        logic b, d, s;
        busyCycles = 0;
        doneAt     = 0;
        stallErr   = 0;
        finished   = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            @(negedge clk);
            b = (which == 0) ? busy0 : busy1;
            d = (which == 0) ? done0 : done1;
            s = (which == 0) ? stall0 : stall1;
            if (s !== b) stallErr++;
            if (b) begin
                busyCycles++;
                if (d) doneAt = busyCycles;
            end else if (busyCycles > 0) begin
                finished = 1'b1;
            end
        end
        checkOutput({name, " finished in time"}, {63'd0, finished}, 64'd1);
        checkOutput({name, " stall_req==busy"}, 64'(stallErr), 64'd0);
    endtask

    task automatic waitIdx(input int idx, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            if (if0.out_valid && if0.out_idx == ADDR_W'(idx)) ok = 1'b1;
        end
        checkOutput({name, " reached beat"}, {63'd0, ok}, 64'd1);
    endtask

    initial begin
        int busyCycles, doneAt, b0, d0;
        int unused;

        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA000_0000 | (i * 32'h0001_0101);
        regs[0]  = 32'd0;
        regs[5]  = 32'hDEAD_BEEF;
        regs[31] = 32'h1234_5678;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset out_valid", {63'd0, if0.out_valid}, 64'd0);
        checkOutput("reset busy", {63'd0, busy0}, 64'd0);
        checkOutput("reset stall_req", {63'd0, stall0}, 64'd0);
        checkOutput("reset done", {63'd0, done0}, 64'd0);
        checkOutput("reset rf_addr", {59'd0, rf_addr0}, 64'd0);
        checkOutput("reset out_data", {32'd0, if0.out_data}, 64'd0);
        checkOutput("reset out_idx", {59'd0, if0.out_idx}, 64'd0);
        checkOutput("reset out_last", {63'd0, if0.out_last}, 64'd0);

        $display("[TB] full dump, ready tied high");
        b0 = beats0; d0 = dones0;
        pushDump(0, 0);
        applyStimulus(0, 1'b1, 1'b0);
        runUntilIdle(0, "full", busyCycles, doneAt);
        checkOutput("full busy cycles", 64'(busyCycles), 64'd65);
        checkOutput("full done cycle", 64'(doneAt), 64'd65);
        checkOutput("full beats", 64'(beats0 - b0), 64'd32);
        checkOutput("full done pulses", 64'(dones0 - d0), 64'd1);
        checkOutput("full queue drained", 64'(expq0.size()), 64'd0);

        $display("[TB] backpressure at idx 7");
        b0 = beats0; d0 = dones0;
        pushDump(0, 0);
        applyStimulus(0, 1'b1, 1'b0);
        waitIdx(7, "bp");
        if0.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp valid held", {63'd0, if0.out_valid}, 64'd1);
            checkOutput("bp idx held", {59'd0, if0.out_idx}, 64'd7);
            checkOutput("bp data held", {32'd0, if0.out_data}, {32'd0, regs[7]});
        end
        @(posedge clk); #1;
        if0.out_ready = 1'b1;
        runUntilIdle(0, "bp", busyCycles, doneAt);
        checkOutput("bp beats", 64'(beats0 - b0), 64'd32);
        checkOutput("bp done pulses", 64'(dones0 - d0), 64'd1);
        checkOutput("bp queue drained", 64'(expq0.size()), 64'd0);

        $display("[TB] skip x0");
        pushDump(1, 1);
        applyStimulus(1, 1'b1, 1'b0);
        runUntilIdle(1, "skip", busyCycles, doneAt);
        checkOutput("skip beats", 64'(beats1), 64'd31);
        checkOutput("skip done pulses", 64'(dones1), 64'd1);
        checkOutput("skip busy cycles", 64'(busyCycles), 64'd63);
        checkOutput("skip queue drained", 64'(expq1.size()), 64'd0);

        $display("[TB] abort at idx 10");
        b0 = beats0; d0 = dones0;
        pushDump(0, 0);
        applyStimulus(0, 1'b1, 1'b0);
        waitIdx(10, "abort");
        if0.out_ready = 1'b0;
        abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        @(negedge clk);
        checkOutput("abort out_valid", {63'd0, if0.out_valid}, 64'd0);
        checkOutput("abort busy", {63'd0, busy0}, 64'd0);
        checkOutput("abort rf_addr", {59'd0, rf_addr0}, 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort no done", 64'(dones0 - d0), 64'd0);
        checkOutput("abort beats taken", 64'(beats0 - b0), 64'd10);
        checkOutput("abort beats left", 64'(expq0.size()), 64'd22);
        expq0.delete();
        if0.out_ready = 1'b1;
        b0 = beats0; d0 = dones0;
        pushDump(0, 0);
        applyStimulus(0, 1'b1, 1'b0);
        runUntilIdle(0, "post-abort", busyCycles, doneAt);
        checkOutput("post-abort beats", 64'(beats0 - b0), 64'd32);
        checkOutput("post-abort done", 64'(dones0 - d0), 64'd1);

        $display("[TB] start with abort in idle");
        applyStimulus(0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("start+abort busy", {63'd0, busy0}, 64'd0);

        $display("[TB] start re-pulsed while busy");
        b0 = beats0; d0 = dones0;
        pushDump(0, 0);
        applyStimulus(0, 1'b1, 1'b0);
        waitIdx(3, "repulse");
        applyStimulus(0, 1'b1, 1'b0);
        unused = 0;
        for (int c = 0; c < 400 && !done0; c++) begin
            @(posedge clk); #1;
            unused++;
        end
        checkOutput("repulse saw done", {63'd0, done0}, 64'd1);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("repulse idle after", {63'd0, busy0}, 64'd0);
        checkOutput("repulse beats", 64'(beats0 - b0), 64'd32);
        checkOutput("repulse done pulses", 64'(dones0 - d0), 64'd1);
        checkOutput("repulse queue drained", 64'(expq0.size()), 64'd0);

        $display("[TB] reset with start mid-dump at idx 20");
        b0 = beats0;
        pushDump(0, 0);
        applyStimulus(0, 1'b1, 1'b0);
        waitIdx(20, "reset");
        reset  = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        checkOutput("midreset out_valid", {63'd0, if0.out_valid}, 64'd0);
        checkOutput("midreset out_data", {32'd0, if0.out_data}, 64'd0);
        checkOutput("midreset out_idx", {59'd0, if0.out_idx}, 64'd0);
        checkOutput("midreset out_last", {63'd0, if0.out_last}, 64'd0);
        checkOutput("midreset busy", {63'd0, busy0}, 64'd0);
        checkOutput("midreset stall_req", {63'd0, stall0}, 64'd0);
        checkOutput("midreset done", {63'd0, done0}, 64'd0);
        checkOutput("midreset rf_addr", {59'd0, rf_addr0}, 64'd0);
        @(negedge clk);
        checkOutput("midreset stays idle", {63'd0, busy0}, 64'd0);
        checkOutput("midreset beats taken", 64'(beats0 - b0), 64'd20);
        checkOutput("midreset beats left", 64'(expq0.size()), 64'd12);
        expq0.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential read-side client of the 32x32 register file.
- On a start pulse it walks every register through one regfile read port and streams each value out over a valid/ready interface, with index and last flag.
- Used for debug/trace dump and end-of-test signature extraction.
- Holds the core off the regfile write port via stall_req while active.

Parameters:
- NUM_REGS, 32, number of registers walked.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- SKIP_X0, 0, if 1 the dump starts at register 1 and x0 is not emitted.

Ports:
- clk  input  1  clock; all state changes at posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  synchronous cancel of an active dump.
- rf_addr  output  ADDR_W  read address to the regfile port (rs1 or rs2).
- rf_data  input  DATA_W  combinational read value returned by the regfile for rf_addr.
- out_valid  output  1  out_data/out_idx/out_last hold a beat.
- out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both 1 at posedge.
- out_data  output  DATA_W  register value.
- out_idx  output  ADDR_W  register number of the beat.
- out_last  output  1  beat is register NUM_REGS-1.
- busy  output  1  high in any state other than IDLE.
- stall_req  output  1  equal to busy; the core must not assert regfile we while high.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, idx 0, rf_addr 0, out_valid 0, out_data 0, out_idx 0, out_last 0, done 0, busy 0, stall_req 0.
- Reset has priority over start and abort in the same cycle.
- States: IDLE, FETCH, SEND, DONE. All outputs are registered except rf_addr, which is the idx register.
- IDLE:
  - rf_addr = 0.
  - start=1 -> FETCH with idx = SKIP_X0 ? 1 : 0.
- FETCH (one cycle):
  - rf_addr = idx.
  - At posedge: out_data <= rf_data, out_idx <= idx, out_last <= (idx == NUM_REGS-1), out_valid <= 1.
  - Next state SEND.
- SEND:
  - out_valid = 1; out_data, out_idx and out_last are held stable while out_ready = 0.
  - On handshake: out_valid <= 0. If out_last -> DONE, else idx <= idx+1 -> FETCH.
- DONE (one cycle): done = 1, then IDLE.
- Throughput: 2 cycles per beat minimum. A full dump with SKIP_X0=0 and out_ready tied to 1 takes 65 cycles from the start sample edge to the done pulse.
- No wrap-around: idx never exceeds NUM_REGS-1. Width is ADDR_W; the increment is unsigned with no overflow by construction.
- start while busy (including in DONE) is ignored; there is no queuing.
- abort in FETCH/SEND/DONE:
  - Next state is IDLE; out_valid drops even without a handshake; done is not pulsed.
  - Consumers must tolerate a dropped beat on abort.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and the dump does not start.
- reset mid-dump: same effect as abort plus the reset values above.
- rf_data must be returned combinationally in the same cycle as rf_addr, as the regfile provides. x0 reads as 0.

Decomposition:
- Package regfile_pkg holds NUM_REGS, ADDR_W, DATA_W and the dump_state_t enum (IDLE, FETCH, SEND, DONE), shared with the regfile and the core's stall logic.
- No sub-module. Single FSM plus idx counter plus output register.

Test Plan:
- Full dump, ready=1: preload x5=0xDEADBEEF, x31=0x12345678, pulse start -> 32 beats with idx 0..31; beat 0 data 0; beat 5 = 0xDEADBEEF; beat 31 = 0x12345678 with out_last=1; done pulses 65 cycles after the start edge; busy/stall_req high throughout.
- Backpressure: hold out_ready=0 for 3 cycles when idx=7 is presented -> out_valid stays 1 and out_data/out_idx=7 stay stable; the dump then resumes with idx 8 and 32 beats total.
- SKIP_X0=1 -> 31 beats; first out_idx=1, last out_idx=31 with out_last=1; done pulses once.
- abort asserted on the SEND cycle of idx 10 -> next cycle out_valid=0, busy=0; done never pulses; a following start dumps from idx 0.
- start re-pulsed at idx 3, and again in the DONE cycle -> both ignored; exactly 32 beats and one done pulse.
- reset asserted mid-dump at idx 20 together with start -> all outputs at reset values next cycle; state IDLE.
